fp_norm_shift: RTL
==================

FP_NORM_SHIFT -- requirements
Module: fp_norm_shift

Interface
REQ-001 Parameter WIDTH, default 64, datapath width; power of 2, 8..128.
REQ-002 Parameter STEP, default 8, maximum left-shift bits per cycle; power of 2, 1..WIDTH.
REQ-003 Derived constant SAW = log2(WIDTH).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 hold  input  1  pipeline freeze, FPU hold equivalent.
REQ-007 in_valid  input  1  operand offered.
REQ-008 in_ready  output  1  block can accept an operand.
REQ-009 in_data  input  WIDTH  mantissa to shift.
REQ-010 in_mode  input  1  0 = normalise by leading-zero count; 1 = explicit shift by in_shamt.
REQ-011 in_shamt  input  SAW  explicit shift amount.
REQ-012 in_sticky  input  1  sticky bit carried with the operand.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_data  output  WIDTH  shifted mantissa.
REQ-016 out_lzc  output  SAW+1  leading-zero count of in_data, range 0..WIDTH.
REQ-017 out_zero  output  1  in_data was all zeros.
REQ-018 out_sticky  output  1  registered copy of in_sticky.
REQ-019 out_ovf  output  1  a 1 bit was shifted out past the MSB (explicit mode only).

Function
REQ-020 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-021 in_ready SHALL equal (state==IDLE && !hold).
REQ-022 Accept on (in_valid && in_ready): the block SHALL register the data, the sticky bit and the lzc, and SHALL set rem = in_mode ? in_shamt : lzc.
REQ-023 On accept, the next state SHALL be SHIFT if rem != 0 and in_data != 0; otherwise it SHALL be DONE.
REQ-024 Each non-hold SHIFT cycle SHALL left-shift by k = min(rem, STEP) with zero fill, decrement rem by k, and move to DONE when rem reaches 0.
REQ-025 Latency: out_valid SHALL rise ceil(rem/STEP)+1 cycles after the accept edge, plus one cycle for each cycle hold is high.
REQ-026 A zero operand SHALL give out_zero=1, out_lzc=WIDTH and out_data=0, and SHALL reach DONE with no SHIFT cycles in either mode.
REQ-027 In normalise mode on a nonzero operand, out_data[WIDTH-1] SHALL be 1 and out_ovf SHALL be 0.
REQ-028 out_ovf SHALL be the OR of every bit shifted out across all SHIFT cycles.
REQ-029 In DONE, out_valid SHALL be 1 and all outputs SHALL stay stable until out_ready; the transfer (out_valid && out_ready && !hold) SHALL return the FSM to IDLE.
REQ-030 hold=1 SHALL freeze the state, rem, the data and all outputs; no accept or output transfer SHALL occur while hold is high.
REQ-031 The block SHALL NOT accept an operand in the same cycle that it transfers a result (no back-to-back overlap).

Reset
REQ-032 reset=1 SHALL, at the next clk edge, set the state to IDLE, out_valid to 0, and out_data, out_lzc, out_zero, out_sticky, out_ovf and rem to 0, with priority over hold.
REQ-033 Reset asserted mid-SHIFT or in DONE SHALL discard the operation with no result transferred; in_ready SHALL be 1 in the first cycle after reset deasserts, provided hold is low.

Configuration
REQ-034 When macro FP_NORM_OVF_EN is defined, out_ovf SHALL be computed per REQ-028.
REQ-035 When FP_NORM_OVF_EN is undefined, out_ovf SHALL be tied to 0, the overflow-accumulation logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=64, STEP=8, FP_NORM_OVF_EN defined)
REQ-036 Normalise in_data=0x0000_0000_0000_1234 -> out_lzc=51, out_data=0x91A0_0000_0000_0000, out_ovf=0, out_valid 8 cycles after accept.
REQ-037 Normalise in_data=0 with in_sticky=1 -> out_zero=1, out_lzc=64, out_data=0, out_sticky=1, out_valid 1 cycle after accept.
REQ-038 Explicit shift, in_shamt=12, in_data=0xF000_0000_0000_0001 -> out_data=0x0000_0000_0000_1000, out_ovf=1, out_lzc=0, out_valid 3 cycles after accept.
REQ-039 Hold out_ready low for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; transfer on the 6th cycle; in_ready=1 on the next cycle.
REQ-040 Raise hold for 3 cycles during the REQ-036 operation -> out_valid 11 cycles after accept, with identical results.
REQ-041 Assert reset during the 4th SHIFT cycle -> next cycle out_valid=0, all outputs 0, and in_ready=1 after reset deasserts.

Source files
------------

// File: rtl/fp_norm_shift.sv
// fp_norm_shift: multi-cycle mantissa left shifter.
// Normalises by leading-zero count or shifts by an explicit amount, at most
// STEP bits per cycle, with a valid/ready handshake and a global hold.
// Optional feature macro: FP_NORM_OVF_EN enables the shifted-out overflow flag;
// when it is undefined out_ovf is tied low.
module fp_norm_shift #(
   parameter int WIDTH = 64,
   parameter int STEP  = 8,
   localparam int SAW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   input  logic [SAW-1:0]   in_shamt,
   input  logic             in_sticky,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SAW:0]     out_lzc,
   output logic             out_zero,
   output logic             out_sticky,
   output logic             out_ovf
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [SAW:0] LP_STEP  = (SAW+1)'(STEP);
   localparam logic [SAW:0] LP_WIDTH = (SAW+1)'(WIDTH);

   logic [1:0]       r_state;
   logic [SAW:0]     r_rem;
   logic [WIDTH-1:0] r_data;
   logic [SAW:0]     r_lzc;
   logic             r_zero;
   logic             r_sticky;

   logic [SAW:0]     w_lzc;
   logic [SAW:0]     w_rem_init;
   logic [SAW:0]     w_k;
   logic [WIDTH-1:0] w_shifted;
   logic             w_in_zero;

   // Leading-zero count of the offered operand; the highest set bit wins.
   always_comb begin
      w_lzc = LP_WIDTH;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (in_data[i]) begin
            w_lzc = (SAW+1)'(WIDTH - 1 - i);
         end
      end
   end

   // Shift amount selection and the per-cycle shift step.
   always_comb begin
      w_in_zero  = (in_data == '0);
      w_rem_init = in_mode ? {1'b0, in_shamt} : w_lzc;
      w_k        = (r_rem > LP_STEP) ? LP_STEP : r_rem;
      w_shifted  = r_data << w_k;
   end

   assign in_ready   = (r_state == ST_IDLE) && !hold;
   assign out_valid  = (r_state == ST_DONE);
   assign out_data   = r_data;
   assign out_lzc    = r_lzc;
   assign out_zero   = r_zero;
   assign out_sticky = r_sticky;

   // Control FSM and datapath registers; hold freezes everything except reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_rem    <= '0;
         r_data   <= '0;
         r_lzc    <= '0;
         r_zero   <= 1'b0;
         r_sticky <= 1'b0;
      end else if (!hold) begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_data   <= in_data;
                  r_lzc    <= w_lzc;
                  r_zero   <= w_in_zero;
                  r_sticky <= in_sticky;
                  r_rem    <= w_rem_init;
                  if ((w_rem_init != '0) && !w_in_zero) begin
                     r_state <= ST_SHIFT;
                  end else begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               r_data <= w_shifted;
               r_rem  <= r_rem - w_k;
               if (r_rem == w_k) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef FP_NORM_OVF_EN
   logic             r_ovf;
   logic             w_lost;

   // Any 1 in the top k bits is pushed past the MSB by this step.
   always_comb begin
      w_lost = |(r_data & ~({WIDTH{1'b1}} >> w_k));
   end

   // Sticky OR of every bit lost across the whole operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (!hold) begin
         if ((r_state == ST_IDLE) && in_valid) begin
            r_ovf <= 1'b0;
         end else if (r_state == ST_SHIFT) begin
            r_ovf <= r_ovf | w_lost;
         end
      end
   end

   assign out_ovf = r_ovf;
`else
   assign out_ovf = 1'b0;
`endif

endmodule
